// File: rtl/idecode_pkg.sv
// Shared decode definitions: widths, opcode/funct codes, field positions, op classes.
// Used by dec_fields, idecode and the bench.
package idecode_pkg;

  localparam int WORD = 32;
  localparam int ADDR = 32;
  localparam int REGW = 5;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int TGT_HI = 25;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ALU  = 4'd1,
    OP_ADDI = 4'd2,
    OP_LOGI = 4'd3,
    OP_LW   = 4'd4,
    OP_SW   = 4'd5,
    OP_BEQ  = 4'd6,
    OP_J    = 4'd7
  } op_e;

  typedef struct packed {
    op_e             op;
    logic [REGW-1:0] rs;
    logic [REGW-1:0] rt;
    logic [REGW-1:0] rd;
    logic [WORD-1:0] imm;
    logic            we;
    logic            ld;
    logic            illegal;
  } dec_t;

  // Opcodes whose rt field is a source operand.
  function automatic logic reads_rt(input logic [5:0] opc);
    return (opc == OPC_RTYPE) || (opc == OPC_SW) ||
           (opc == OPC_BEQ);
  endfunction

endpackage

// File: rtl/idecode_fields.sv
// Combinational field split of one instruction word into decode bundle.
// Unknown opcodes or R-type functs flag illegal and decode as OP_NOP.
module dec_fields
  import idecode_pkg::*;
(
  input  logic [WORD-1:0] inst,
  output dec_t            dec
);

  logic [5:0]      opc;
  logic [5:0]      fn;
  logic [WORD-1:0] sx;
  logic [WORD-1:0] zx;
  logic            wcls;

  assign opc = inst[OPC_HI:OPC_LO];
  assign fn  = inst[FN_HI:FN_LO];
  assign sx  = {{(WORD-16){inst[IMM_HI]}}, inst[IMM_HI:0]};
  assign zx  = {{(WORD-16){1'b0}}, inst[IMM_HI:0]};

  // Opcode class, destination and immediate selection.
  always_comb begin
    dec         = '0;
    dec.op      = OP_NOP;
    dec.rs      = inst[RS_HI:RS_LO];
    dec.rt      = inst[RT_HI:RT_LO];
    dec.rd      = inst[RT_HI:RT_LO];
    dec.imm     = sx;
    wcls        = 1'b0;
    unique case (opc)
      OPC_RTYPE: begin
        unique case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
            dec.op = OP_ALU;
            dec.rd = inst[RD_HI:RD_LO];
            wcls   = 1'b1;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_ADDI: begin
        dec.op = OP_ADDI;
        wcls   = 1'b1;
      end
      OPC_ANDI, OPC_ORI: begin
        dec.op  = OP_LOGI;
        dec.imm = zx;
        wcls    = 1'b1;
      end
      OPC_LW: begin
        dec.op = OP_LW;
        dec.ld = 1'b1;
        wcls   = 1'b1;
      end
      OPC_SW:  dec.op = OP_SW;
      OPC_BEQ: dec.op = OP_BEQ;
      OPC_J: begin
        dec.op  = OP_J;
        dec.imm = {{(WORD-26){1'b0}}, inst[TGT_HI:0]};
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.we = wcls && (dec.rd != '0);
  end

endmodule

// File: rtl/idecode.sv
// Decode stage: pipeline register, load-use hazard check, flush/stall priority.
// Optional DEC_ILLEGAL_TRAP_EN: flag illegal encodings and stop accepting until flush.
module idecode
  import idecode_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            v_i,
  input  logic [WORD-1:0] inst_i,
  input  logic [ADDR-1:0] pc_i,
  input  logic            flush_i,
  input  logic            stall_i,
  output logic            stall_o,
  output logic            v_o,
  output logic [ADDR-1:0] pc_o,
  output op_e             op_o,
  output logic [REGW-1:0] rs_o,
  output logic [REGW-1:0] rt_o,
  output logic [REGW-1:0] rd_o,
  output logic [WORD-1:0] imm_o,
  output logic            we_o,
  output logic            ld_o,
  output logic            illegal_o
);

  dec_t dec;
  logic hazard;
  logic sticky;
  logic acc;

  dec_fields u_fields (
    .inst (inst_i),
    .dec  (dec)
  );

  assign hazard = !flush_i && v_o && ld_o && v_i &&
                  (rd_o != '0) &&
                  ((rd_o == inst_i[RS_HI:RS_LO]) ||
                   ((rd_o == inst_i[RT_HI:RT_LO]) &&
                    reads_rt(inst_i[OPC_HI:OPC_LO])));

  assign stall_o = stall_i || hazard;
  assign acc     = v_i && !sticky;

`ifdef DEC_ILLEGAL_TRAP_EN
  // Illegal flag follows the instruction; sticky lock holds until flush.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      sticky    <= 1'b0;
      illegal_o <= 1'b0;
    end else if (stall_i) begin
      sticky    <= sticky;
    end else if (hazard) begin
      illegal_o <= 1'b0;
    end else begin
      illegal_o <= dec.illegal && acc;
      sticky    <= sticky || (dec.illegal && acc);
    end
  end
`else
  assign sticky    = 1'b0;
  assign illegal_o = 1'b0;
`endif

  // Pipeline register: reset > flush > stall > bubble > capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_o   <= 1'b0;
      pc_o  <= '0;
      op_o  <= OP_NOP;
      rs_o  <= '0;
      rt_o  <= '0;
      rd_o  <= '0;
      imm_o <= '0;
      we_o  <= 1'b0;
      ld_o  <= 1'b0;
    end else if (flush_i || (!stall_i && hazard)) begin
      v_o  <= 1'b0;
      we_o <= 1'b0;
      ld_o <= 1'b0;
    end else if (!stall_i) begin
      v_o   <= acc;
      pc_o  <= pc_i;
      op_o  <= dec.op;
      rs_o  <= dec.rs;
      rt_o  <= dec.rt;
      rd_o  <= dec.rd;
      imm_o <= dec.imm;
      we_o  <= dec.we && acc;
      ld_o  <= dec.ld && acc;
    end
  end

endmodule

// File: tb/tb_idecode.sv
// Bench for idecode: directed scenarios then random traffic vs a reference model.
// Model decodes from the instruction format table; DEC_ILLEGAL_TRAP_EN adds trap cases.
module tb_idecode;
  import idecode_pkg::*;

  logic        clk = 1'b0;
  logic        rst, v_i, flush_i, stall_i;
  logic [31:0] inst_i, pc_i;
  logic        stall_o, v_o, we_o, ld_o, illegal_o;
  logic [31:0] pc_o, imm_o;
  op_e         op_o;
  logic [4:0]  rs_o, rt_o, rd_o;

  idecode dut (
    .clk       (clk),
    .rst       (rst),
    .v_i       (v_i),
    .inst_i    (inst_i),
    .pc_i      (pc_i),
    .flush_i   (flush_i),
    .stall_i   (stall_i),
    .stall_o   (stall_o),
    .v_o       (v_o),
    .pc_o      (pc_o),
    .op_o      (op_o),
    .rs_o      (rs_o),
    .rt_o      (rt_o),
    .rd_o      (rd_o),
    .imm_o     (imm_o),
    .we_o      (we_o),
    .ld_o      (ld_o),
    .illegal_o (illegal_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic        wr, ld, ill, immk;
  } rdec_t;

  typedef struct {
    logic        v, we, ld, ill, sticky, clr;
    logic [31:0] pc, imm;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd;
    logic        immk;
  } mst_t;

  mst_t m;
  logic st_seen;

`ifdef DEC_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  function automatic rdec_t ref_dec(input logic [31:0] w);
    rdec_t d;
    int opc = int'(w[31:26]);
    int fn  = int'(w[5:0]);
    logic [31:0] sx = {{16{w[15]}}, w[15:0]};
    d.rs = w[25:21]; d.rt = w[20:16]; d.rd = w[20:16];
    d.op = OP_NOP; d.imm = 0; d.wr = 0; d.ld = 0;
    d.ill = 0; d.immk = 0;
    if (opc == 0) begin
      if (fn inside {32, 34, 36, 37, 42}) begin
        d.op = OP_ALU; d.rd = w[15:11]; d.wr = 1;
      end else d.ill = 1;
    end else if (opc == 8) begin
      d.op = OP_ADDI; d.imm = sx; d.wr = 1; d.immk = 1;
    end else if (opc == 12 || opc == 13) begin
      d.op = OP_LOGI; d.imm = {16'h0, w[15:0]};
      d.wr = 1; d.immk = 1;
    end else if (opc == 35) begin
      d.op = OP_LW; d.imm = sx; d.wr = 1; d.ld = 1; d.immk = 1;
    end else if (opc == 43) begin
      d.op = OP_SW; d.imm = sx; d.immk = 1;
    end else if (opc == 4) begin
      d.op = OP_BEQ; d.imm = sx; d.immk = 1;
    end else if (opc == 2) begin
      d.op = OP_J; d.imm = {6'h0, w[25:0]}; d.immk = 1;
    end else d.ill = 1;
    return d;
  endfunction

  function automatic logic ref_hz(input logic vi, input logic [31:0] w,
                                  input logic fl);
    logic rt_src = (w[31:26] == 6'h00) || (w[31:26] == 6'h2B) ||
                   (w[31:26] == 6'h04);
    return !fl && m.v && m.ld && vi && (m.rd != 0) &&
           ((m.rd == w[25:21]) || (m.rd == w[20:16] && rt_src));
  endfunction

  task automatic model_edge(input logic r, vi, input logic [31:0] w,
                            input logic [31:0] pc, input logic fl, st);
    rdec_t d;
    logic a;
    if (r) begin
      m = '{default: '0};
      m.clr = 1;
    end else if (fl) begin
      m.v = 0; m.we = 0; m.ld = 0; m.ill = 0; m.sticky = 0;
    end else if (st) begin
    end else if (ref_hz(vi, w, fl)) begin
      m.v = 0; m.we = 0; m.ld = 0; m.ill = 0;
    end else begin
      d = ref_dec(w);
      a = vi && !m.sticky;
      m.v = a; m.pc = pc; m.op = d.op;
      m.rs = d.rs; m.rt = d.rt; m.rd = d.rd;
      m.imm = d.imm; m.immk = d.immk;
      m.we = d.wr && (d.rd != 0) && a;
      m.ld = d.ld && a;
      m.ill = TRAP && d.ill && a;
      m.sticky = m.sticky || m.ill;
      m.clr = 0;
    end
  endtask

  task automatic step(input logic r, vi, input logic [31:0] w,
                      input logic [31:0] pc, input logic fl, st);
    @(negedge clk);
    rst = r; v_i = vi; inst_i = w; pc_i = pc;
    flush_i = fl; stall_i = st;
    #1;
    st_seen = stall_o;
    chk("stall_o", stall_o, st || ref_hz(vi, w, fl));
    @(posedge clk);
    model_edge(r, vi, w, pc, fl, st);
    #1;
    chk("v_o", v_o, m.v);
    chk("we_o", we_o, m.we);
    chk("ld_o", ld_o, m.ld);
    chk("illegal_o", illegal_o, m.ill);
    if (m.clr) begin
      chk("rst_pc", pc_o, 0);
      chk("rst_op", op_o, OP_NOP);
      chk("rst_imm", imm_o, 0);
      chk("rst_rd", rd_o, 0);
    end
    if (m.v) begin
      chk("pc_o", pc_o, m.pc);
      chk("op_o", op_o, m.op);
      if (m.op != OP_NOP) begin
        chk("rs_o", rs_o, m.rs);
        chk("rt_o", rt_o, m.rt);
        chk("rd_o", rd_o, m.rd);
      end
      if (m.immk) chk("imm_o", imm_o, m.imm);
    end
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [5:0] opcs [10] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23,
                              6'h2B, 6'h04, 6'h02, 6'h3F, 6'h11};
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h07};
    logic [5:0] o = opcs[$urandom_range(0, 9)];
    logic [4:0] s = 5'($urandom_range(0, 3));
    logic [4:0] t = 5'($urandom_range(0, 3));
    logic [4:0] d = 5'($urandom_range(0, 3));
    if (o == 6'h00)
      return {o, s, t, d, 5'($urandom), fns[$urandom_range(0, 5)]};
    return {o, s, t, 16'($urandom)};
  endfunction

  localparam logic [31:0] LW_R2  = 32'h8C22_0000;
  localparam logic [31:0] ADD_R3 = 32'h0044_1820;
  localparam logic [31:0] ADDI   = 32'h2001_FFFD;

  initial begin
    rst = 1; v_i = 0; inst_i = 0; pc_i = 0;
    flush_i = 0; stall_i = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, LW_R2, 32'h4, 0, 1);
    chk("rst_stall", st_seen, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_v", v_o, 0);

    step(0, 1, ADDI, 32'h100, 0, 0);
    chk("t1_op", op_o, OP_ADDI);
    chk("t1_rd", rd_o, 1);
    chk("t1_imm", imm_o, 32'hFFFF_FFFD);
    chk("t1_we", we_o, 1);

    step(0, 1, LW_R2, 32'h104, 0, 0);
    step(0, 1, ADD_R3, 32'h108, 0, 0);
    chk("t2_stall", st_seen, 1);
    chk("t2_bubble", v_o, 0);
    step(0, 1, ADD_R3, 32'h108, 0, 0);
    chk("t2_stall2", st_seen, 0);
    chk("t2_rs", rs_o, 2);
    chk("t2_v", v_o, 1);

    step(0, 1, 32'h8C20_0000, 32'h10C, 0, 0);
    step(0, 1, 32'h0000_1820, 32'h110, 0, 0);
    chk("t3_stall", st_seen, 0);
    chk("t3_we_r0ld", we_o, 1);

    step(0, 1, ADDI, 32'h200, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 32'h2002_0000 + i, 32'h204 + 4 * i, 0, 1);
      chk("t4_stall", st_seen, 1);
      chk("t4_pc", pc_o, 32'h200);
    end

    step(0, 1, LW_R2, 32'h300, 0, 0);
    step(0, 1, ADD_R3, 32'h304, 1, 1);
    chk("t5_v", v_o, 0);
    chk("t5_we", we_o, 0);
    step(0, 1, LW_R2, 32'h300, 0, 0);
    step(0, 1, ADD_R3, 32'h304, 1, 0);
    chk("t5_nohz", st_seen, 0);

`ifdef DEC_ILLEGAL_TRAP_EN
    step(0, 1, 32'hFC00_0000, 32'h400, 0, 0);
    chk("t6_ill", illegal_o, 1);
    chk("t6_v", v_o, 1);
    step(0, 1, ADDI, 32'h404, 0, 0);
    chk("t6_lock", v_o, 0);
    step(0, 1, ADDI, 32'h408, 1, 0);
    step(0, 1, ADDI, 32'h500, 0, 0);
    chk("t6_resume", v_o, 1);
    chk("t6_op", op_o, OP_ADDI);
`endif

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) < 2,
           $urandom_range(0, 99) < 85,
           rnd_inst(),
           $urandom,
           $urandom_range(0, 99) < 8,
           $urandom_range(0, 99) < 15);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idecode.md
Name: idecode

Overview:
- Decode stage directly downstream of instruction fetch.
- Captures the fetched instruction word and its address into a pipeline register and splits it into register/immediate/control fields for execute.
- Detects load-use hazards and back-pressures fetch via stall_o.
- Accepts a flush from execute when a branch resolves taken.

Parameters:
- WORD, 32, instruction/data word width (from shared params)
- ADDR, 32, instruction address width (from shared params)
- REGW, 5, register index width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset; synchronous, active-high
- v_i  in  1  fetched instruction valid
- inst_i  in  WORD  fetched instruction
- pc_i  in  ADDR  address of fetched instruction
- flush_i  in  1  taken branch from execute; kill instruction held in decode
- stall_i  in  1  downstream not accepting; hold decode register
- stall_o  out  1  to fetch: hold fetch address (hazard or stall_i)
- v_o  out  1  decoded instruction valid
- pc_o  out  ADDR  registered instruction address
- op_o  out  4  decoded operation class (package enum)
- rs_o, rt_o, rd_o  out  REGW each  source/dest indices (rd_o = rt for I-type)
- imm_o  out  WORD  sign- or zero-extended immediate
- we_o  out  1  writes register file
- ld_o  out  1  instruction is a load
- illegal_o  out  1  only with DEC_ILLEGAL_TRAP_EN, else tied 0

Behaviour:
- Format: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0], imm [15:0].
- Opcode classes:
  - 0x00 R-type ALU: funct selects ADD/SUB/AND/OR/SLT; we=1; dest rd.
  - 0x08 ADDI: sign-extend.
  - 0x0C ANDI, 0x0D ORI: zero-extend.
  - 0x23 LW: ld=1, we=1, dest rt.
  - 0x2B SW: we=0.
  - 0x04 BEQ: we=0, imm sign-extended.
  - 0x02 J: imm = zero-extended [25:0].
  - Anything else decodes to OP_NOP with we=0.
- Register update each cycle, priority order:
  1. rst: all outputs 0; op_o = OP_NOP.
  2. flush_i: v_o <= 0; other fields don't-care, but we_o and ld_o forced 0. Flush beats stall_i and hazard.
  3. stall_i: hold all registers.
  4. hazard: insert bubble (v_o <= 0, we_o <= 0, ld_o <= 0); fetch is held by stall_o so the same instruction is re-presented next cycle.
  5. else: capture decode of inst_i; v_o <= v_i. When v_i = 0, we_o and ld_o are also 0.
- Hazard (combinational): asserted when all hold:
  - v_o & ld_o & v_i
  - rd_o != 0
  - rd_o == rs(inst_i), or rd_o == rt(inst_i) and the incoming op reads rt (R-type, SW, BEQ)
  - Hazard is suppressed when flush_i = 1.
- stall_o = stall_i | hazard. This is combinational and has no registered delay.
- Latency: 1 cycle from inst_i to decoded outputs.
- Register 0 as destination: we_o = 0.
- Reset mid-stall: rst wins; next cycle v_o = 0 and stall_o = stall_i only.

Optional Feature:
- Macro: DEC_ILLEGAL_TRAP_EN
- With it defined:
  - An unrecognised opcode, or an R-type with an unknown funct, sets illegal_o together with v_o for that instruction.
  - A sticky internal flag then drops v_i acceptance: following instructions are registered with v_o = 0 until rst or flush_i.
- Without it: illegal_o is tied 0 and unknown encodings become OP_NOP with v_o preserved.

Decomposition:
- Shared package/header (next to params): opcode and funct constants, the op-class enum (OP_NOP, OP_ALU, OP_ADDI, OP_LOGI, OP_LW, OP_SW, OP_BEQ, OP_J), and the field bit positions.
- One natural sub-module: dec_fields, purely combinational, mapping inst → {op, rs, rt, rd, imm, we, ld, illegal}.
- idecode holds the pipeline register, the hazard check and the priority logic.

Test Plan:
1. ADDI r1,r0,-3 (0x2001FFFD), v_i=1 → next cycle v_o=1, op=OP_ADDI, rd_o=1, imm_o=0xFFFFFFFD, we_o=1.
2. LW r2,0(r1) then ADD r3,r2,r4 → stall_o=1 for exactly 1 cycle, one bubble (v_o=0), then ADD decoded with rs_o=2.
3. LW r0,.. followed by a use of r0 → no hazard, stall_o=0.
4. stall_i=1 held 3 cycles while new inst_i changes → outputs frozen; stall_o=1 throughout.
5. flush_i=1 coincident with stall_i=1 and a hazard → v_o=0, we_o=0 next cycle, and the hazard does not drive stall_o.
6. With DEC_ILLEGAL_TRAP_EN, opcode 0x3F → illegal_o=1 and v_o=1 once, then v_o=0 until flush_i, after which a valid ADDI is decoded.
